// File: rtl/dmem_arbiter.sv
// Two-port (pipeline / debug) arbiter in front of a byte-wide data RAM; each grant moves one 64-bit word as 8 byte beats.
// Define DMEM_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise the pipeline port has fixed priority.
module dmem_arbiter #(
  parameter int unsigned MAX_SIZE = 1024
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        p_req_i,
  input  logic        p_we_i,
  input  logic [63:0] p_addr_i,
  input  logic [63:0] p_wdata_i,
  output logic        p_ack_o,
  output logic [63:0] p_rdata_o,
  output logic        p_err_o,
  input  logic        d_req_i,
  input  logic        d_we_i,
  input  logic [63:0] d_addr_i,
  input  logic [63:0] d_wdata_i,
  output logic        d_ack_o,
  output logic [63:0] d_rdata_o,
  output logic        d_err_o,
  output logic [63:0] ram_addr_o,
  output logic [7:0]  ram_wdata_o,
  output logic        ram_we_o,
  input  logic [7:0]  ram_rdata_i,
  output logic        busy_o
);

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_e;
  typedef enum logic {OWN_P = 1'b0, OWN_D = 1'b1} owner_e;

  localparam logic [64:0] MAX_BYTES = 65'(MAX_SIZE);

  state_e      state_q, state_d;
  owner_e      owner_q;
  logic        we_q;
  logic [63:0] addr_q, wdata_q;
  logic [2:0]  beat_q;
  logic [63:0] rbuf_q, rbuf_next;
  logic        any_req, grant_d, in_range;
  logic [63:0] gnt_addr;
  logic [64:0] end_addr;

  assign any_req = p_req_i | d_req_i;

`ifdef DMEM_ROUND_ROBIN_EN
  logic prio_d_q;  // 1 when the debug port wins the next tie

  assign grant_d = d_req_i & (~p_req_i | prio_d_q);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)                       prio_d_q <= 1'b0;
    else if (state_q == IDLE && any_req) prio_d_q <= ~grant_d;
  end
`else
  assign grant_d = d_req_i & ~p_req_i;
`endif

  assign gnt_addr = grant_d ? d_addr_i : p_addr_i;
  // Widened by one bit so addresses near 2^64 cannot wrap into range.
  assign end_addr = {1'b0, gnt_addr} + 65'd7;
  assign in_range = end_addr < MAX_BYTES;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    // NOTE: default first so no path through this block infers a latch.
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (any_req) state_d = in_range ? XFER : DONE;
      XFER:    if (beat_q == 3'd7) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_o      = (state_q != IDLE);
    p_ack_o     = (state_q == DONE) && (owner_q == OWN_P);
    d_ack_o     = (state_q == DONE) && (owner_q == OWN_D);
    ram_we_o    = 1'b0;
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    if (state_q == XFER) begin
      ram_we_o    = we_q;
      ram_addr_o  = addr_q + 64'(beat_q);
      ram_wdata_o = wdata_q[{beat_q, 3'b000} +: 8];
    end
  end

  // Read word including the byte arriving in the current beat.
  always_comb begin
    rbuf_next = rbuf_q;
    rbuf_next[{beat_q, 3'b000} +: 8] = ram_rdata_i;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      owner_q <= OWN_P;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      beat_q  <= '0;
      rbuf_q  <= '0;
    end else if (state_q == IDLE && any_req) begin
      owner_q <= grant_d ? OWN_D : OWN_P;
      we_q    <= grant_d ? d_we_i : p_we_i;
      addr_q  <= gnt_addr;
      wdata_q <= grant_d ? d_wdata_i : p_wdata_i;
      beat_q  <= '0;
      rbuf_q  <= '0;
    end else if (state_q == XFER) begin
      beat_q <= beat_q + 3'd1;
      if (!we_q) rbuf_q <= rbuf_next;
    end
  end

  // Per-port results change only on that port's completion and are held otherwise.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      p_err_o   <= 1'b0;
      p_rdata_o <= '0;
      d_err_o   <= 1'b0;
      d_rdata_o <= '0;
    end else if (state_q == IDLE && any_req && !in_range) begin
      if (grant_d) begin
        d_err_o   <= 1'b1;
        d_rdata_o <= '0;
      end else begin
        p_err_o   <= 1'b1;
        p_rdata_o <= '0;
      end
    end else if (state_q == XFER && beat_q == 3'd7) begin
      if (owner_q == OWN_D) begin
        d_err_o   <= 1'b0;
        d_rdata_o <= we_q ? 64'd0 : rbuf_next;
      end else begin
        p_err_o   <= 1'b0;
        p_rdata_o <= we_q ? 64'd0 : rbuf_next;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: vector table for single transactions, hand sequences for reset and contention.
module tb_dmem_arbiter;

  logic        clk_i, rst_n_i;
  logic        p_req_i, p_we_i, d_req_i, d_we_i;
  logic [63:0] p_addr_i, p_wdata_i, d_addr_i, d_wdata_i;
  logic        p_ack_o, p_err_o, d_ack_o, d_err_o;
  logic [63:0] p_rdata_o, d_rdata_o, ram_addr_o;
  logic [7:0]  ram_wdata_o, ram_rdata_i;
  logic        ram_we_o, busy_o;

  dmem_arbiter #(.MAX_SIZE(1024)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .p_req_i(p_req_i), .p_we_i(p_we_i), .p_addr_i(p_addr_i), .p_wdata_i(p_wdata_i),
    .p_ack_o(p_ack_o), .p_rdata_o(p_rdata_o), .p_err_o(p_err_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
    .d_ack_o(d_ack_o), .d_rdata_o(d_rdata_o), .d_err_o(d_err_o),
    .ram_addr_o(ram_addr_o), .ram_wdata_o(ram_wdata_o), .ram_we_o(ram_we_o),
    .ram_rdata_i(ram_rdata_i), .busy_o(busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Byte RAM model
  logic [7:0] mem [0:1023];
  int we_cnt = 0;
  always @(posedge clk_i) begin
    if (ram_we_o) begin
      we_cnt <= we_cnt + 1;
      if (ram_addr_o < 64'd1024) mem[ram_addr_o[9:0]] <= ram_wdata_o;
    end
  end
  assign ram_rdata_i = (ram_addr_o < 64'd1024) ? mem[ram_addr_o[9:0]] : 8'h00;

  // Protocol monitors
  int both_ack = 0, idle_drive = 0, long_ack = 0, ack_cnt = 0;
  logic p_ack_prev = 1'b0, d_ack_prev = 1'b0;
  always @(negedge clk_i) begin
    if (p_ack_o && d_ack_o) both_ack <= both_ack + 1;
    if (!busy_o && (ram_we_o || ram_addr_o != 64'd0)) idle_drive <= idle_drive + 1;
    if ((p_ack_o && p_ack_prev) || (d_ack_o && d_ack_prev)) long_ack <= long_ack + 1;
    ack_cnt    <= ack_cnt + int'(p_ack_o) + int'(d_ack_o);
    p_ack_prev <= p_ack_o;
    d_ack_prev <= d_ack_o;
  end

  int checks = 0, errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input bit port, input bit req, input bit we,
                       input logic [63:0] addr, input logic [63:0] wdata);
    if (!port) begin
      p_req_i = req; p_we_i = we; p_addr_i = addr; p_wdata_i = wdata;
    end else begin
      d_req_i = req; d_we_i = we; d_addr_i = addr; d_wdata_i = wdata;
    end
  endtask

  task automatic set_req(input bit port, input bit req);
    if (!port) p_req_i = req;
    else       d_req_i = req;
  endtask

  // who: 0 = p, 1 = d, 2 = timeout, 3 = both acks together
  task automatic wait_ack(output int who, output int cyc, input bit scr, input bit port);
    cyc = 0;
    who = 2;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk_i);
      cyc++;
      if (scr && cyc == 1) begin
        #1 drive(port, 1'b1, 1'($urandom), {$urandom, $urandom}, {$urandom, $urandom});
      end
      @(negedge clk_i);
      if (p_ack_o && d_ack_o) begin who = 3; break; end
      if (p_ack_o) begin who = 0; break; end
      if (d_ack_o) begin who = 1; break; end
    end
  endtask

  typedef struct {
    string       name;
    bit          port;
    bit          we;
    logic [63:0] addr;
    logic [63:0] wdata;
    bit          exp_err;
    logic [63:0] exp_rdata;
    int          exp_lat;
  } vec_t;

  task automatic run_vec(input vec_t v);
    int who, cyc;
    @(negedge clk_i);
    drive(v.port, 1'b1, v.we, v.addr, v.wdata);
    wait_ack(who, cyc, 1'b1, v.port);
    drive(v.port, 1'b0, 1'b0, 64'd0, 64'd0);
    check({v.name, " owner"}, 64'(who), 64'(v.port));
    check({v.name, " latency"}, 64'(cyc), 64'(v.exp_lat));
    check({v.name, " err"}, 64'(v.port ? d_err_o : p_err_o), 64'(v.exp_err));
    if (!v.we || v.exp_err)
      check({v.name, " rdata"}, v.port ? d_rdata_o : p_rdata_o, v.exp_rdata);
    repeat (3) @(negedge clk_i);
    check({v.name, " ack pulse"}, 64'(v.port ? d_ack_o : p_ack_o), 64'd0);
    if (!v.we || v.exp_err)
      check({v.name, " rdata held"}, v.port ? d_rdata_o : p_rdata_o, v.exp_rdata);
  endtask

  vec_t vecs[10];
  int   who, cyc, we_snap, ack_snap;

  initial begin
    vecs[0] = '{"wr p 0x18",   1'b0, 1'b1, 64'h18,  64'h0807060504030201, 1'b0, 64'h0, 9};
    vecs[1] = '{"rd d 0x18",   1'b1, 1'b0, 64'h18,  64'h0,                1'b0, 64'h0807060504030201, 9};
    vecs[2] = '{"rd p 1020",   1'b0, 1'b0, 64'd1020, 64'h0,               1'b1, 64'h0, 1};
    vecs[3] = '{"rd p wrap",   1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 1'b1, 64'h0, 1};
    vecs[4] = '{"wr d 1016",   1'b1, 1'b1, 64'd1016, 64'h1122334455667788, 1'b0, 64'h0, 9};
    vecs[5] = '{"rd p 1016",   1'b0, 1'b0, 64'd1016, 64'h0,               1'b0, 64'h1122334455667788, 9};
    vecs[6] = '{"wr d 1017",   1'b1, 1'b1, 64'd1017, 64'hFFFF,            1'b1, 64'h0, 1};
    vecs[7] = '{"wr p 0x100",  1'b0, 1'b1, 64'h100, 64'hDEADBEEFCAFEF00D, 1'b0, 64'h0, 9};
    vecs[8] = '{"rd d 0x100",  1'b1, 1'b0, 64'h100, 64'h0,                1'b0, 64'hDEADBEEFCAFEF00D, 9};
    vecs[9] = '{"wr p 0x200",  1'b0, 1'b1, 64'h200, 64'h0,                1'b0, 64'h0, 9};

    rst_n_i = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
    drive(1'b1, 1'b0, 1'b0, 64'd0, 64'd0);
    #12;
    check("reset flags", {58'd0, p_ack_o, d_ack_o, p_err_o, d_err_o, busy_o, ram_we_o}, 64'd0);
    check("reset p_rdata", p_rdata_o, 64'd0);
    check("reset d_rdata", d_rdata_o, 64'd0);
    check("reset ram_addr", ram_addr_o, 64'd0);
    check("reset ram_wdata", 64'(ram_wdata_o), 64'd0);
    @(negedge clk_i) rst_n_i = 1'b1;

    for (int i = 0; i < 10; i++) begin
      if (i == 2 || i == 6) we_snap = we_cnt;
      run_vec(vecs[i]);
      if (i == 0)
        for (int b = 0; b < 8; b++) check("ram byte 0x18+", 64'(mem[10'h18 + 10'(b)]), 64'(b + 1));
      if (i == 3) begin
        check("no ram write on err", 64'(we_cnt), 64'(we_snap));
        check("d_rdata held over p", d_rdata_o, 64'h0807060504030201);
        check("d_err held over p", 64'(d_err_o), 64'd0);
      end
      if (i == 6) check("no ram write on d err", 64'(we_cnt), 64'(we_snap));
    end

    // Reset during beat 3 of a write
    @(negedge clk_i);
    drive(1'b0, 1'b1, 1'b1, 64'h200, 64'hAABBCCDDEEFF1122);
    repeat (4) @(posedge clk_i);
    @(negedge clk_i);
    check("beat3 we", 64'(ram_we_o), 64'd1);
    check("beat3 addr", ram_addr_o, 64'h203);
    ack_snap = ack_cnt;
    rst_n_i = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
    #1;
    check("rst we", 64'(ram_we_o), 64'd0);
    check("rst busy", 64'(busy_o), 64'd0);
    check("rst ack", 64'(p_ack_o), 64'd0);
    check("rst addr", ram_addr_o, 64'd0);
    @(negedge clk_i) rst_n_i = 1'b1;
    repeat (12) @(negedge clk_i);
    check("no ack after abort", 64'(ack_cnt), 64'(ack_snap));
    check("abort bytes", {mem[10'h203], mem[10'h202], mem[10'h201], mem[10'h200]}, 64'h00FF1122);
    run_vec('{"rd p after rst", 1'b0, 1'b0, 64'h200, 64'h0, 1'b0, 64'h0000000000FF1122, 9});

    // Contention from a freshly reset pointer
    @(negedge clk_i) rst_n_i = 1'b0;
    @(negedge clk_i) rst_n_i = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 64'h18, 64'h0);
    drive(1'b1, 1'b1, 1'b0, 64'h100, 64'h0);
    wait_ack(who, cyc, 1'b0, 1'b0);
    check("A1 owner", 64'(who), 64'd0);
    check("A1 latency", 64'(cyc), 64'd9);
    check("A1 rdata", p_rdata_o, 64'h0807060504030201);
    set_req(1'b0, 1'b0);
    wait_ack(who, cyc, 1'b0, 1'b0);
    check("A2 owner", 64'(who), 64'd1);
    check("A2 gap", 64'(cyc), 64'd10);
    check("A2 rdata", d_rdata_o, 64'hDEADBEEFCAFEF00D);
    set_req(1'b1, 1'b0);

    @(negedge clk_i);
    set_req(1'b0, 1'b1);
    set_req(1'b1, 1'b1);
    wait_ack(who, cyc, 1'b0, 1'b0);
    check("B1 owner", 64'(who), 64'd0);
    check("B1 latency", 64'(cyc), 64'd9);
`ifdef DMEM_ROUND_ROBIN_EN
    wait_ack(who, cyc, 1'b0, 1'b0);
    check("B2 owner rr", 64'(who), 64'd1);
    check("B2 gap", 64'(cyc), 64'd10);
    set_req(1'b1, 1'b0);
    wait_ack(who, cyc, 1'b0, 1'b0);
    check("B3 owner rr", 64'(who), 64'd0);
    check("B3 gap", 64'(cyc), 64'd10);
    set_req(1'b0, 1'b0);
`else
    wait_ack(who, cyc, 1'b0, 1'b0);
    check("B2 owner fixed", 64'(who), 64'd0);
    check("B2 gap", 64'(cyc), 64'd10);
    set_req(1'b0, 1'b0);
    wait_ack(who, cyc, 1'b0, 1'b0);
    check("B3 owner fixed", 64'(who), 64'd1);
    check("B3 gap", 64'(cyc), 64'd10);
    set_req(1'b1, 1'b0);
`endif
    repeat (3) @(negedge clk_i);
    check("idle busy", 64'(busy_o), 64'd0);

    check("both acks together", 64'(both_ack), 64'd0);
    check("ram driven outside xfer", 64'(idle_drive), 64'd0);
    check("ack longer than 1 cycle", 64'(long_ack), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter MAX_SIZE, default 1024, meaning the number of bytes of the byte-wide data RAM; legal byte addresses are 0..MAX_SIZE-1.
REQ-002 SHALL have port clk_i, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n_i, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL have port p_req_i, input, 1: pipeline-port request, held high until p_ack_o.
REQ-005 SHALL have port p_we_i, input, 1: pipeline-port write (1) / read (0).
REQ-006 SHALL have ports p_addr_i and p_wdata_i, input, 64 each: pipeline-port byte address and store data.
REQ-007 SHALL have ports p_ack_o (output, 1), p_rdata_o (output, 64) and p_err_o (output, 1): pipeline-port completion pulse, load data and address error.
REQ-008 SHALL have ports d_req_i, d_we_i, d_addr_i and d_wdata_i, plus d_ack_o, d_rdata_o and d_err_o: the debug/loader port, with the same widths and meanings as the pipeline port.
REQ-009 SHALL have port ram_addr_o, output, 64: byte address to the RAM.
REQ-010 SHALL have ports ram_wdata_o (output, 8) and ram_we_o (output, 1): RAM write byte and write enable, written on the clk_i edge.
REQ-011 SHALL have port ram_rdata_i, input, 8: RAM read byte, combinational from ram_addr_o.
REQ-012 SHALL have port busy_o, output, 1: high whenever the FSM is not IDLE.

Function
REQ-013 SHALL implement an FSM with states IDLE, XFER and DONE.
REQ-014 In IDLE with any request sampled high in cycle T, SHALL latch the granted port's we, addr and wdata, and record the grant owner.
REQ-015 Range check: SHALL go to XFER for cycles T+1..T+8 when addr+7 < MAX_SIZE, compared at 65-bit width so there is no wrap-around; otherwise SHALL go directly to DONE in T+1 with err=1, no RAM access and rdata=0.
REQ-016 In XFER beat k (k=0..7, 3-bit counter), SHALL drive ram_addr_o=addr+k, ram_wdata_o=wdata[8k+7:8k] and ram_we_o=we.
REQ-017 On a read, SHALL capture ram_rdata_i into rdata[8k+7:8k] at the end of beat k (little-endian).
REQ-018 After beat 7, SHALL go to DONE; DONE lasts one cycle (T+9 on success), in which only the owner's ack_o is 1 and its err_o/rdata_o are valid.
REQ-019 SHALL hold each port's rdata_o and err_o until that port's next completion.
REQ-020 Outside XFER, SHALL hold ram_we_o=0 and ram_addr_o=0.
REQ-021 SHALL ignore requests sampled in DONE; it returns to IDLE at T+10, and a req still high then is a new request.
REQ-022 SHALL ignore changes to the requester's inputs after the grant; it uses only the latched values.
REQ-023 On simultaneous requests in IDLE, SHALL arbitrate per REQ-027/REQ-028; the losing request stays pending and SHALL be served next with no lost cycle beyond the DONE cycle.
REQ-024 SHALL keep ack_o a single-cycle pulse and never assert both ack_o signals in the same cycle.

Reset
REQ-025 On rst_n_i=0, SHALL immediately force state IDLE and drive every output (all ack, err, rdata, ram_*, busy_o) to 0, and clear the round-robin pointer so the pipeline port has priority.
REQ-026 On reset mid-XFER, SHALL abort the access with no ack; RAM bytes already written remain written.

Configuration
REQ-027 With DMEM_ROUND_ROBIN_EN defined, SHALL grant simultaneous requests to the port not granted last; the pointer updates on each grant, including error grants.
REQ-028 With DMEM_ROUND_ROBIN_EN undefined, SHALL use fixed priority, with the pipeline port always winning; no pointer register is generated.

Verification
REQ-029 Write: p write, addr=0x18, wdata=0x0807060504030201 -> RAM bytes 0x18..0x1F = 01..08; p_ack_o 9 cycles after the request is sampled; p_err_o=0.
REQ-030 Read: d read, addr=0x18 after REQ-029 -> d_rdata_o=0x0807060504030201 in the ack cycle and held afterwards.
REQ-031 Error: p read, addr=1020 with MAX_SIZE=1024 -> p_ack_o at T+1, p_err_o=1, p_rdata_o=0, ram_we_o never 1; likewise addr=0xFFFFFFFFFFFFFFFC gives err=1 (no wrap-around).
REQ-032 Contention: p and d both request in the same cycle, twice in a row -> p then d served with DMEM_ROUND_ROBIN_EN, and p then d with it undefined; with it undefined and p re-requesting at once, p is served again while d waits.
REQ-033 Reset: assert rst_n_i at XFER beat 3 of a write -> ram_we_o=0 immediately, no ack, busy_o=0, only bytes 0..2 written; the next request completes normally.
